uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_core.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// UART receiver core: oversampled start/data/parity/stop capture with a
// single-entry output holding register, valid/ready handoff and sticky
// error/overrun flags. The receive FSM never waits on the consumer.
module uart_rx_core #(
  parameter int unsigned OVERSAMPLE = 16,   // baud ticks per bit, even, 8..32
  parameter bit          PARITY_EN  = 1'b1, // 1: a parity bit follows the data
  parameter bit          PARITY_ODD = 1'b0  // 0: even parity, 1: odd parity
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_tick,
  input  logic       rx_in,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned    TW      = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]  TC_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]  TC_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0]  TC_ONE  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Receive-side state
  logic [1:0]    r_sync;
  state_t        r_state;
  logic [TW-1:0] r_tcnt;
  logic [2:0]    r_bcnt;
  logic [7:0]    r_shift;
  logic          r_par_bad;

  // Output holding register
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_parity_err;
  logic          r_frame_err;
  logic          r_overrun;

  // Next-state values and per-clk events
  logic          w_rx_s;
  state_t        w_state_nxt;
  logic [TW-1:0] w_tcnt_nxt;
  logic [2:0]    w_bcnt_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_par_bad_nxt;
  logic          w_done;
  logic          w_stop_bad;
  logic          w_accept;

  assign w_rx_s   = r_sync[1];
  assign w_accept = r_rx_valid & rx_ready;

  // Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would collapse the two stages into one.
    if (!reset_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], rx_in};
  end

  // FSM state register plus its tick/bit counters and data shifter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_tcnt    <= '0;
      r_bcnt    <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_shift   <= w_shift_nxt;
      r_par_bad <= w_par_bad_nxt;
    end
  end

  // Next-state logic: count baud ticks, sample mid-bit, flag frame completion.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    w_state_nxt   = r_state;
    w_tcnt_nxt    = r_tcnt;
    w_bcnt_nxt    = r_bcnt;
    w_shift_nxt   = r_shift;
    w_par_bad_nxt = r_par_bad;
    w_done        = 1'b0;
    w_stop_bad    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = S_START;
          w_tcnt_nxt  = '0;
        end
      end
      S_START: begin
        if (baud_tick) begin
          if (r_tcnt == TC_HALF) begin
            // Line back high at mid start bit means a glitch, not a frame.
            w_state_nxt   = w_rx_s ? S_IDLE : S_DATA;
            w_tcnt_nxt    = '0;
            w_bcnt_nxt    = '0;
            w_par_bad_nxt = 1'b0;
          end else begin
            w_tcnt_nxt = r_tcnt + TC_ONE;
          end
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (r_tcnt == TC_LAST) begin
            w_tcnt_nxt  = '0;
            w_shift_nxt = {w_rx_s, r_shift[7:1]};
            w_bcnt_nxt  = r_bcnt + 3'd1;
            if (r_bcnt == 3'd7) w_state_nxt = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            w_tcnt_nxt = r_tcnt + TC_ONE;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          if (r_tcnt == TC_LAST) begin
            w_tcnt_nxt    = '0;
            w_par_bad_nxt = (^r_shift) ^ w_rx_s ^ PARITY_ODD;
            w_state_nxt   = S_STOP;
          end else begin
            w_tcnt_nxt = r_tcnt + TC_ONE;
          end
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (r_tcnt == TC_LAST) begin
            w_tcnt_nxt  = '0;
            w_done      = 1'b1;
            w_stop_bad  = ~w_rx_s;
            w_state_nxt = S_IDLE;
          end else begin
            w_tcnt_nxt = r_tcnt + TC_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tcnt_nxt  = '0;
      end
    endcase
  end

  // Output holding register: load on completion when free or being accepted,
  // otherwise drop the new frame and flag overrun; a bare accept empties it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_data    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_done) begin
      if (!r_rx_valid || rx_ready) begin
        r_rx_data    <= w_shift_nxt;
        r_parity_err <= PARITY_EN & r_par_bad;
        r_frame_err  <= w_stop_bad;
        r_rx_valid   <= 1'b1;
        r_overrun    <= 1'b0;
      end else begin
        r_overrun    <= 1'b1;
      end
    end else if (w_accept) begin
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core: directed frames plus randomized frames, with a
// queue of expected frames consumed by an independent output monitor.
module tb_uart_rx_core;

  localparam int unsigned OS         = 16;
  localparam bit          PARITY_EN  = 1'b1;
  localparam bit          PARITY_ODD = 1'b0;
  localparam int          CLK_PER_TICK = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int tick_div = 0;
  int valid_run = 0;
  int valid_last_len = 0;
  int valid_frames = 0;
  bit rand_on = 1'b0;

  uart_rx_core #(
    .OVERSAMPLE (OS),
    .PARITY_EN  (PARITY_EN),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .baud_tick  (baud_tick),
    .rx_in      (rx_in),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Baud tick: one clk out of every CLK_PER_TICK, changed away from the rising edge.
  always @(negedge clk) begin
    baud_tick = (tick_div == CLK_PER_TICK - 1);
    tick_div  = (tick_div + 1) % CLK_PER_TICK;
  end

  // Track how many clks each rx_valid assertion lasts.
  always @(negedge clk) begin
    if (rx_valid) valid_run++;
    else if (valid_run != 0) begin
      valid_last_len = valid_run;
      valid_run = 0;
      valid_frames++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted frame is compared against the oldest expectation.
  always @(negedge clk) begin
    #1;
    if (reset_n && rx_valid && rx_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n * CLK_PER_TICK) @(negedge clk);
  endtask

  // Serialise one frame; the expected result is derived from the frame bits.
  task automatic send_frame(input logic [7:0] d, input bit wrong_par,
                            input bit stop_bit, input bit expect_it);
    logic pbit;
    exp_t e;
    pbit   = (^d) ^ PARITY_ODD ^ wrong_par;
    e.data = d;
    e.perr = PARITY_EN ? (((^d) ^ pbit) != PARITY_ODD) : 1'b0;
    e.ferr = ~stop_bit;
    if (expect_it) sb.push_back(e);
    rx_in = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      wait_ticks(OS);
    end
    if (PARITY_EN) begin
      rx_in = pbit;
      wait_ticks(OS);
    end
    rx_in = stop_bit;
    // A low stop bit is released shortly after its middle so the line's
    // return high lands well before the next mid start-bit sample.
    wait_ticks(stop_bit ? OS : OS / 2 + 2);
    rx_in = 1'b1;
    wait_ticks(2 * OS);
  endtask

  initial begin
    int frames_before;
    // Reset state
    reset_n  = 1'b0;
    rx_in    = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_flags", {29'd0, parity_err, frame_err, overrun}, 32'd0);
    reset_n = 1'b1;
    wait_ticks(4);

    // Clean frame, consumer always ready: one-clk valid pulse
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    check("a5_valid_pulse_len", 32'(valid_last_len), 32'd1);
    check("a5_sb_empty", 32'(sb.size()), 32'd0);

    // Glitch shorter than half a bit: false start
    frames_before = valid_frames;
    rx_in = 1'b0;
    wait_ticks(2);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    wait_ticks(2);
    rx_in = 1'b1;
    wait_ticks(12);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    check("glitch_no_valid", 32'(valid_frames), 32'(frames_before));
    check("glitch_rx_valid", {31'd0, rx_valid}, 32'd0);

    // Wrong parity, bad stop bit, and a break
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    check("err_sb_empty", 32'(sb.size()), 32'd0);

    // Overrun: two frames with the consumer stalled
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    check("ovr_rx_valid", {31'd0, rx_valid}, 32'd1);
    check("ovr_rx_data", {24'd0, rx_data}, 32'h11);
    check("ovr_overrun", {31'd0, overrun}, 32'd1);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("ovr_accept_valid", {31'd0, rx_valid}, 32'd0);
    check("ovr_accept_overrun", {31'd0, overrun}, 32'd0);
    check("ovr_accept_data_kept", {24'd0, rx_data}, 32'h11);
    check("ovr_sb_empty", 32'(sb.size()), 32'd0);
    rx_ready = 1'b1;

    // Reset in the middle of data bit 4, then a clean frame
    rx_in = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rx_in = (i % 2 == 0);
      wait_ticks(OS);
    end
    rx_in = 1'b1;
    wait_ticks(OS / 2);
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_ticks(2 * OS);
    check("midreset_idle", {31'd0, busy}, 32'd0);
    frames_before = valid_frames;
    send_frame(8'h81, 1'b0, 1'b1, 1'b1);
    check("midreset_one_frame", 32'(valid_frames - frames_before), 32'd1);

    // Randomized frames with a randomly stalling consumer
    rand_on = 1'b1;
    fork
      begin
        for (int n = 0; n < 20; n++) begin
          logic [7:0] d;
          bit wp;
          bit sb_bit;
          d      = 8'($urandom_range(0, 255));
          wp     = ($urandom_range(0, 3) == 0);
          sb_bit = ($urandom_range(0, 6) != 0);
          send_frame(d, wp, sb_bit, 1'b1);
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(negedge clk);
          rx_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rx_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    check("final_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
